// File: rtl/sb_pkg.sv
// Shared types for the memory-stage store buffer.
// Contents: FSM state enum, store-buffer entry struct, byte-address helper.
// The entry is sized by SB_AW/SB_DW; the top's AW/DW default to these widths.
package sb_pkg;

  localparam int unsigned SB_AW = 32;
  localparam int unsigned SB_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    LDONE
  } sb_state_t;

  typedef struct packed {
    logic [SB_AW-3:0] waddr;  // word address (byte address >> 2)
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_AW-1:0] byte_addr(input logic [SB_AW-3:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/store_buffer_mem_if.sv
// Request/acknowledge data-memory bus.
// master: controller side (drives mem_req/mem_we/mem_addr/mem_wdata).
// slave:  memory side (drives mem_ack one-cycle pulse and mem_rdata).
interface store_buffer_mem_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/sb_fifo.sv
// In-order circular store buffer.
// Ports: clk/reset; push + push_entry enqueue at the tail; pop removes the head;
// head shows the oldest entry; lookup_waddr -> hit/hit_data give the youngest
// valid entry with that word address (combinational); count/full/empty status.
module sb_fifo import sb_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  sb_entry_t              push_entry,
  input  logic                   pop,
  output sb_entry_t              head,
  input  logic [SB_AW-3:0]       lookup_waddr,
  output logic                   hit,
  output logic [SB_DW-1:0]       hit_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] idx;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage needs no reset: only slots covered by count_q are ever observed.
  always_ff @(posedge clk) begin
    if (push) entries_q[wr_ptr_q] <= push_entry;
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (entries_q[idx].waddr == lookup_waddr)) begin
        hit      = 1'b1;
        hit_data = entries_q[idx].data;
      end
    end
  end

  assign head  = entries_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/store_buffer_mem.sv
// Memory-stage controller: absorbs stores into a store buffer drained in the
// background, forwards load hits from the buffer, and fetches load misses.
// Ports: clk, reset (async, active high); M-stage memwritem/memtoregm/aluoutm/
// writedatam; rdm (load result), stallm (freeze pipeline), sb_count (occupancy);
// mem: req/ack memory bus (master side), all request fields registered.
module store_buffer_mem import sb_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwritem,
  input  logic                   memtoregm,
  input  logic [AW-1:0]          aluoutm,
  input  logic [DW-1:0]          writedatam,
  output logic [DW-1:0]          rdm,
  output logic                   stallm,
  output logic [$clog2(DEPTH):0] sb_count,
  store_buffer_mem_if.master     mem
);

  sb_state_t     state_q;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] ld_q;
  logic [DW-1:0] rdm_q;

  logic          is_store;
  logic          is_load;
  logic          load_miss;
  logic          push;
  logic          pop;
  logic          hit;
  logic          sb_full;
  logic          sb_empty;
  logic [DW-1:0] hit_data;
  logic [AW-3:0] waddr;
  sb_entry_t     push_entry;
  sb_entry_t     head;
  logic          unused_lsb;

  assign waddr      = aluoutm[AW-1:2];
  assign unused_lsb = ^aluoutm[1:0];

  // A store wins when both strobes are high.
  assign is_store   = memwritem;
  assign is_load    = memtoregm & ~memwritem;
  // The held load is already satisfied in LDONE; do not detect it again.
  assign load_miss  = is_load & ~hit & (state_q != LDONE);
  // Full is judged on the registered count, so a same-cycle ack does not admit.
  assign push       = is_store & ~sb_full;
  assign pop        = (state_q == WRITE) & mem.mem_ack;
  assign stallm     = (is_store & sb_full) | load_miss;
  assign push_entry = '{waddr: waddr, data: writedatam};

  sb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .lookup_waddr(waddr),
    .hit         (hit),
    .hit_data    (hit_data),
    .count       (sb_count),
    .full        (sb_full),
    .empty       (sb_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A pending miss implies no buffered store to that word, so it may go first.
          if (load_miss) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= {waddr, 2'b00};
            state_q <= READ;
          end else if (!sb_empty) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= byte_addr(head.waddr);
            wdata_q <= head.data;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (mem.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= load_miss ? READ : IDLE;
          end
        end
        READ: begin
          // Entered from WRITE with req low: issue the read one cycle after the ack.
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= {waddr, 2'b00};
          end else if (mem.mem_ack) begin
            req_q   <= 1'b0;
            ld_q    <= mem.mem_rdata;
            state_q <= LDONE;
          end
        end
        LDONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // rdm keeps its last value whenever no load is being answered.
  always_comb begin
    rdm = rdm_q;
    if (state_q == LDONE) begin
      rdm = ld_q;
    end else if (is_load && hit) begin
      rdm = hit_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdm_q <= '0;
    end else begin
      rdm_q <= rdm;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_buffer_mem.sv
module tb_store_buffer_mem;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwritem = 1'b0;
  logic        memtoregm = 1'b0;
  logic [31:0] aluoutm = '0;
  logic [31:0] writedatam = '0;
  logic [31:0] rdm;
  logic        stallm;
  logic [2:0]  sb_count;

  store_buffer_mem_if #(.AW(32), .DW(32)) mb ();

  store_buffer_mem #(
    .DEPTH(DEPTH),
    .AW   (32),
    .DW   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwritem (memwritem),
    .memtoregm (memtoregm),
    .aluoutm   (aluoutm),
    .writedatam(writedatam),
    .rdm       (rdm),
    .stallm    (stallm),
    .sb_count  (sb_count),
    .mem       (mb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stores in program order, pending (undrained) stores, memory.
  ent_t        pend[$];
  logic [31:0] mem_arr [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] exp_rdm = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  // Memory responder controls.
  bit ack_en = 1'b1;
  bit ack_once = 1'b0;
  int lat = 0;
  int wcnt = 0;

  // Pipeline drive values, applied at the next falling edge.
  logic        drv_w = 1'b0;
  logic        drv_r = 1'b0;
  logic [31:0] drv_a = '0;
  logic [31:0] drv_d = '0;

  // Bus history for stability checks.
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic        p_we = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {2'b00, w} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mem_val(input logic [29:0] w);
    if (mem_arr.exists(w)) return mem_arr[w];
    return dflt(w);
  endfunction

  function automatic logic [31:0] ref_val(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return dflt(w);
  endfunction

  function automatic bit pend_has(input logic [29:0] w);
    foreach (pend[i]) if (pend[i].w == w) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check 1 time unit later, then update
  // the model for what the next rising edge will commit.
  task automatic cycle();
    bit   full_m;
    ent_t e;
    @(negedge clk);
    memwritem  = drv_w;
    memtoregm  = drv_r;
    aluoutm    = drv_a;
    writedatam = drv_d;
    if (!mb.mem_req) begin
      mb.mem_ack = 1'b0;
      wcnt = 0;
    end else if ((ack_en || ack_once) && wcnt >= lat) begin
      mb.mem_ack = 1'b1;
      ack_once = 1'b0;
      wcnt = 0;
    end else begin
      mb.mem_ack = 1'b0;
      wcnt++;
    end
    mb.mem_rdata = (mb.mem_ack && !mb.mem_we) ? mem_val(mb.mem_addr[31:2]) : $urandom;
    #1;
    chk("sb_count", 32'(sb_count), 32'(pend.size()));
    if (mb.mem_req) chk("addr_align", 32'(mb.mem_addr[1:0]), 32'd0);
    if (p_req && !p_ack && mb.mem_req) begin
      chk("hold_we", 32'(mb.mem_we), 32'(p_we));
      chk("hold_addr", mb.mem_addr, p_addr);
      chk("hold_wdata", mb.mem_wdata, p_wdata);
    end
    if (p_ack) chk("req_drop", 32'(mb.mem_req), 32'd0);
    full_m = (pend.size() == DEPTH);
    if (drv_w) chk("store_stall", 32'(stallm), 32'(full_m));
    if (!drv_w && !drv_r) chk("idle_stall", 32'(stallm), 32'd0);
    if (!(drv_r && !drv_w)) chk("rdm_hold", rdm, exp_rdm);
    if (mb.mem_req && mb.mem_ack) begin
      if (mb.mem_we) begin
        chk("drain_nonempty", 32'(pend.size() != 0), 32'd1);
        if (pend.size() != 0) begin
          e = pend.pop_front();
          chk("drain_addr", mb.mem_addr, {e.w, 2'b00});
          chk("drain_data", mb.mem_wdata, e.d);
          mem_arr[e.w] = mb.mem_wdata;
          wr_cnt++;
        end
      end else begin
        chk("read_no_pending", 32'(pend_has(mb.mem_addr[31:2])), 32'd0);
        rd_cnt++;
      end
    end
    if (drv_w && !full_m) begin
      pend.push_back('{w: drv_a[31:2], d: drv_d});
      ref_mem[drv_a[31:2]] = drv_d;
    end
    p_req   = mb.mem_req;
    p_ack   = mb.mem_ack;
    p_we    = mb.mem_we;
    p_addr  = mb.mem_addr;
    p_wdata = mb.mem_wdata;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both);
    drv_w = 1'b1;
    drv_r = both;
    drv_a = a;
    drv_d = d;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (!stallm) begin
        drv_w = 1'b0;
        drv_r = 1'b0;
        return;
      end
    end
    chk("store_timeout", 32'(stallm), 32'd0);
    drv_w = 1'b0;
    drv_r = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    bit          miss;
    int          rd0;
    logic [31:0] expv;
    drv_w = 1'b0;
    drv_r = 1'b1;
    drv_a = a;
    drv_d = $urandom;
    miss  = !pend_has(a[31:2]);
    rd0   = rd_cnt;
    cycle();
    chk("load_first_stall", 32'(stallm), 32'(miss));
    for (int i = 0; i < 100 && stallm; i++) cycle();
    chk("load_timeout", 32'(stallm), 32'd0);
    expv = ref_val(a[31:2]);
    chk("load_data", rdm, expv);
    chk("load_reads", 32'(rd_cnt - rd0), 32'(miss));
    exp_rdm = expv;
    drv_r = 1'b0;
  endtask

  task automatic idle(input int n);
    drv_w = 1'b0;
    drv_r = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    drv_w = 1'b0;
    drv_r = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pend.size() == 0 && !mb.mem_req) return;
      cycle();
    end
    chk("drain_timeout", 32'(pend.size()), 32'd0);
  endtask

  task automatic do_reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    drv_w = 1'b0;
    drv_r = 1'b0;
    memwritem = 1'b0;
    memtoregm = 1'b0;
    mb.mem_ack = 1'b0;
    #1;
    chk("rst_req", 32'(mb.mem_req), 32'd0);
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_stall", 32'(stallm), 32'd0);
    @(negedge clk);
    chk("rst_we", 32'(mb.mem_we), 32'd0);
    chk("rst_addr", mb.mem_addr, 32'd0);
    chk("rst_wdata", mb.mem_wdata, 32'd0);
    chk("rst_rdm", rdm, 32'd0);
    reset = 1'b0;
    pend.delete();
    ref_mem = mem_arr;
    exp_rdm = '0;
    p_req = 1'b0;
    p_ack = 1'b0;
    wcnt = 0;
  endtask

  initial begin
    int          op;
    logic [31:0] a;
    int          wr0;

    mb.mem_ack   = 1'b0;
    mb.mem_rdata = '0;
    do_reset_pulse();
    idle(2);

    // Store drained with a 3-cycle ack delay.
    ack_en = 1'b1;
    lat = 3;
    wr0 = wr_cnt;
    do_store(32'h100, 32'hDEAD_BEEF, 1'b0);
    chk("t1_stall", 32'(stallm), 32'd0);
    drain();
    chk("t1_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("t1_mem", mem_val(30'h40), 32'hDEAD_BEEF);

    // Youngest-entry forwarding with memory stalled.
    ack_en = 1'b0;
    do_store(32'h10, 32'h1, 1'b0);
    do_store(32'h10, 32'h2, 1'b0);
    do_load(32'h10);
    chk("t2_rdm", rdm, 32'h2);
    ack_en = 1'b1;
    drain();

    // Load miss behind an in-flight write drain.
    lat = 4;
    mem_arr[30'h80] = 32'h1234;
    ref_mem[30'h80] = 32'h1234;
    wr0 = wr_cnt;
    do_store(32'h300, 32'hAAAA, 1'b0);
    idle(2);
    chk("t3_write_busy", 32'(mb.mem_req & mb.mem_we), 32'd1);
    do_load(32'h200);
    chk("t3_rdm", rdm, 32'h1234);
    chk("t3_write_done", 32'(wr_cnt - wr0), 32'd1);
    drain();

    // Full buffer: a 5th store waits, an ack frees a slot, accepted next cycle.
    ack_en = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) do_store(32'h1000 + 32'(i * 4), 32'hF000 + 32'(i), 1'b0);
    drv_w = 1'b1;
    drv_r = 1'b0;
    drv_a = 32'h40;
    drv_d = 32'h55;
    repeat (3) cycle();
    chk("t4_full_stall", 32'(stallm), 32'd1);
    ack_once = 1'b1;
    do_store(32'h40, 32'h55, 1'b0);
    idle(1);
    chk("t4_refill", 32'(sb_count), 32'd4);
    ack_en = 1'b1;
    drain();

    // Byte offset ignored: 0x103 stored, 0x100 hits, drained to 0x100.
    lat = 2;
    do_store(32'h103, 32'h77, 1'b0);
    do_load(32'h100);
    chk("t5_rdm", rdm, 32'h77);
    drain();
    chk("t5_mem", mem_val(30'h40), 32'h77);

    // Reset during a write drain discards the buffer.
    ack_en = 1'b0;
    do_store(32'h0, 32'h11, 1'b0);
    do_store(32'h4, 32'h22, 1'b0);
    do_store(32'h8, 32'h33, 1'b0);
    idle(2);
    chk("t6_write_busy", 32'(mb.mem_req & mb.mem_we), 32'd1);
    do_reset_pulse();
    ack_en = 1'b1;
    lat = 1;
    do_load(32'h0);
    chk("t6_rdm", rdm, dflt(30'h0));
    drain();

    // Randomized traffic over a small address window.
    for (int n = 0; n < 400; n++) begin
      op  = $urandom_range(0, 99);
      lat = $urandom_range(0, 3);
      a   = 32'h800 + {26'd0, 4'($urandom_range(0, 7)), 2'($urandom)};
      if (op < 45) begin
        ack_en = (pend.size() < DEPTH) ? ($urandom_range(0, 2) != 0) : 1'b1;
        do_store(a, $urandom, 1'b0);
      end else if (op < 80) begin
        ack_en = 1'b1;
        do_load(a);
      end else if (op < 85) begin
        ack_en = 1'b1;
        do_store(a, $urandom, 1'b1);
      end else begin
        ack_en = 1'b1;
        idle($urandom_range(1, 3));
      end
    end
    ack_en = 1'b1;
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
